// File: rtl/ca_code_gen_if.sv
// ca_code_gen_if: groups the chip-rate control and code outputs of
// ca_code_gen so the NCO side and the correlator side can share one bundle.
//   chip_en  : one-cycle advance strobe from the NCO
//   load     : one-cycle strobe, latch prn and restart at chip 0
//   prn      : satellite number 1..32, only looked at while load=1
//   code_out : current C/A chip
//   chip_idx : index of the current chip, 0..1022
//   epoch    : one-cycle pulse after the index wraps 1022->0
//   valid    : high while a legal PRN is being generated
// master = stimulus/NCO side, slave = code generator.
interface ca_code_gen_if #(
  parameter int PRN_W = 6
);
  logic             chip_en;
  logic             load;
  logic [PRN_W-1:0] prn;
  logic             code_out;
  logic [9:0]       chip_idx;
  logic             epoch;
  logic             valid;

  modport master (
    output chip_en, load, prn,
    input  code_out, chip_idx, epoch, valid
  );

  modport slave (
    input  chip_en, load, prn,
    output code_out, chip_idx, epoch, valid
  );
endinterface

// File: rtl/ca_code_gen.sv
// ca_code_gen: GPS L1 C/A Gold code generator (1023 chips, PRN 1..32).
// Advances one chip per chip_en strobe while running; load restarts the
// code for a new PRN.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous, active-low reset
//   bus : ca_code_gen_if.slave (chip_en, load, prn in; code_out,
//         chip_idx, epoch, valid out)
module ca_code_gen #(
  parameter int PRN_W = 6
) (
  input  logic         clk,
  input  logic         rst,
  ca_code_gen_if.slave bus
);
  // Code length is fixed by the GPS standard.
  localparam int         CODE_LEN = 1023;
  localparam logic [9:0] LAST_IDX = 10'(CODE_LEN - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [10:1]      g1_q, g1_d;
  logic [10:1]      g2_q, g2_d;
  logic [9:0]       idx_q, idx_d;
  logic             epoch_q, epoch_d;
  logic [PRN_W-1:0] prn_q, prn_d;

  logic [3:0] s1, s2;
  logic       prn_legal;
  logic       g1_fb, g2_fb;
  logic       at_last;

  // G2 phase-select taps per PRN. The default (1,1) makes the G2 terms
  // cancel, so code_out stays a clean G1 bit (never X) while idle.
  always_comb begin
    s1 = 4'd1;
    s2 = 4'd1;
    case (32'(prn_q))
      1:  begin s1 = 4'd2; s2 = 4'd6;  end
      2:  begin s1 = 4'd3; s2 = 4'd7;  end
      3:  begin s1 = 4'd4; s2 = 4'd8;  end
      4:  begin s1 = 4'd5; s2 = 4'd9;  end
      5:  begin s1 = 4'd1; s2 = 4'd9;  end
      6:  begin s1 = 4'd2; s2 = 4'd10; end
      7:  begin s1 = 4'd1; s2 = 4'd8;  end
      8:  begin s1 = 4'd2; s2 = 4'd9;  end
      9:  begin s1 = 4'd3; s2 = 4'd10; end
      10: begin s1 = 4'd2; s2 = 4'd3;  end
      11: begin s1 = 4'd3; s2 = 4'd4;  end
      12: begin s1 = 4'd5; s2 = 4'd6;  end
      13: begin s1 = 4'd6; s2 = 4'd7;  end
      14: begin s1 = 4'd7; s2 = 4'd8;  end
      15: begin s1 = 4'd8; s2 = 4'd9;  end
      16: begin s1 = 4'd9; s2 = 4'd10; end
      17: begin s1 = 4'd1; s2 = 4'd4;  end
      18: begin s1 = 4'd2; s2 = 4'd5;  end
      19: begin s1 = 4'd3; s2 = 4'd6;  end
      20: begin s1 = 4'd4; s2 = 4'd7;  end
      21: begin s1 = 4'd5; s2 = 4'd8;  end
      22: begin s1 = 4'd6; s2 = 4'd9;  end
      23: begin s1 = 4'd1; s2 = 4'd3;  end
      24: begin s1 = 4'd4; s2 = 4'd6;  end
      25: begin s1 = 4'd5; s2 = 4'd7;  end
      26: begin s1 = 4'd6; s2 = 4'd8;  end
      27: begin s1 = 4'd7; s2 = 4'd9;  end
      28: begin s1 = 4'd8; s2 = 4'd10; end
      29: begin s1 = 4'd1; s2 = 4'd6;  end
      30: begin s1 = 4'd2; s2 = 4'd7;  end
      31: begin s1 = 4'd3; s2 = 4'd8;  end
      32: begin s1 = 4'd4; s2 = 4'd9;  end
      default: begin s1 = 4'd1; s2 = 4'd1; end
    endcase
  end

  assign prn_legal = (32'(bus.prn) >= 32'd1) && (32'(bus.prn) <= 32'd32);
  assign g1_fb     = g1_q[3] ^ g1_q[10];
  assign g2_fb     = g2_q[2] ^ g2_q[3] ^ g2_q[6] ^ g2_q[8] ^ g2_q[9] ^ g2_q[10];
  assign at_last   = (idx_q == LAST_IDX);

  // Next state. load has priority over chip_en, which also drops any epoch
  // that would have been raised on the same edge.
  always_comb begin
    state_d = state_q;
    g1_d    = g1_q;
    g2_d    = g2_q;
    idx_d   = idx_q;
    epoch_d = 1'b0;
    prn_d   = prn_q;
    if (bus.load) begin
      if (prn_legal) begin
        state_d = RUN;
        prn_d   = bus.prn;
        g1_d    = '1;
        g2_d    = '1;
        idx_d   = '0;
      end else begin
        state_d = IDLE;
      end
    end else if ((state_q == RUN) && bus.chip_en) begin
      if (at_last) begin
        // Reload all-ones at the wrap: matches the natural sequence but
        // re-synchronises the registers should they ever be upset.
        g1_d    = '1;
        g2_d    = '1;
        idx_d   = '0;
        epoch_d = 1'b1;
      end else begin
        // Stage 1 shifts toward stage 10; feedback enters stage 1.
        g1_d  = {g1_q[9:1], g1_fb};
        g2_d  = {g2_q[9:1], g2_fb};
        idx_d = idx_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      g1_q    <= '1;
      g2_q    <= '1;
      idx_q   <= '0;
      epoch_q <= 1'b0;
      prn_q   <= '0;
    end else begin
      state_q <= state_d;
      g1_q    <= g1_d;
      g2_q    <= g2_d;
      idx_q   <= idx_d;
      epoch_q <= epoch_d;
      prn_q   <= prn_d;
    end
  end

  // Chip for the current index, straight from the registers.
  assign bus.code_out = g1_q[10] ^ g2_q[s1] ^ g2_q[s2];
  assign bus.chip_idx = idx_q;
  assign bus.epoch    = epoch_q;
  assign bus.valid    = (state_q == RUN);
endmodule

// File: doc/ca_code_gen.md
Name: ca_code_gen

Overview:
- Downstream consumer of the NCO chip-rate output.
- Generates the GPS L1 C/A Gold code (1023 chips) for a selectable PRN 1..32.
- Advances one chip per single-cycle chip_en strobe from the NCO.
- Supplies code chip, chip index and code-epoch pulse to the correlator/LED debug logic on the iCE40 demo board.

Parameters:
- PRN_W, 6, width of the PRN select input.
- CODE_LEN, 1023, chips per code period; fixed by the GPS standard, not to be overridden.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- chip_en  input  1  one-cycle strobe from the NCO; advance one chip.
- load  input  1  one-cycle strobe; latch prn and restart the code at chip 0.
- prn  input  PRN_W  satellite number 1..32; sampled only when load=1.
- code_out  output  1  current C/A chip.
- chip_idx  output  10  index of the current chip, 0..1022.
- epoch  output  1  one-cycle pulse when the index wraps 1022->0.
- valid  output  1  1 while generating a legal PRN.

Behaviour:
- Reset (rst=0, async):
  - G1 and G2 all ones; chip_idx=0; epoch=0; valid=0; prn_reg=0; state IDLE.
  - code_out is don't-care while valid=0 and must not propagate X.
- States:
  - IDLE: no advance; chip_en is ignored.
  - RUN: advance on chip_en.
- Transitions:
  - load=1 with prn in 1..32 -> RUN from any state. Latch prn, set G1=G2=all ones, chip_idx=0, valid=1 on the next edge.
  - load=1 with prn=0 or prn>32 -> IDLE, valid=0.
- LFSRs: stages are numbered 1..10 and shift from stage 1 toward stage 10.
  - G1 polynomial 1+x^3+x^10; feedback = G1[3]^G1[10].
  - G2 polynomial 1+x^2+x^3+x^6+x^8+x^9+x^10; feedback = G2[2]^G2[3]^G2[6]^G2[8]^G2[9]^G2[10].
- Output: code_out = G1[10] ^ G2[s1] ^ G2[s2].
  - Combinational from registers; it reflects chip chip_idx.
  - Zero latency relative to register state.
- G2 tap pairs (s1,s2), PRN 1..32, decoded from prn_reg by a constant table:
  - PRN 1-8: 2,6 3,7 4,8 5,9 1,9 2,10 1,8 2,9
  - PRN 9-16: 3,10 2,3 3,4 5,6 6,7 7,8 8,9 9,10
  - PRN 17-24: 1,4 2,5 3,6 4,7 5,8 6,9 1,3 4,6
  - PRN 25-32: 5,7 6,8 7,9 8,10 1,6 2,7 3,8 4,9
- Advance in RUN on chip_en=1:
  - Both LFSRs shift once; chip_idx increments.
- Wrap, when chip_idx=1022 and chip_en=1:
  - chip_idx becomes 0 and both LFSRs are forced to all ones. This is equivalent to the natural sequence but guards against corruption.
  - epoch=1 for exactly the following cycle; it is registered on the same edge as the wrap.
- Simultaneous load and chip_en: load wins and chip_en is discarded. An epoch due on that edge is suppressed.
- chip_en on consecutive cycles is legal; each strobe advances exactly one chip.
- prn changes without load have no effect.
- Reset mid-code: immediate return to reset values. The next load is required to restart.

Test Plan:
- Reset, then load prn=1; the first 10 code_out values must be 1100100000 (octal 1440), one per chip_en strobe, with chip_idx stepping 0..9.
- Load prn=2; the first 10 chips must be 1110010000 (octal 1620). Load prn=3 gives octal 1710; prn=4 gives octal 1744.
- prn=1, 1023 chip_en strobes spaced 5 clocks:
  - epoch pulses exactly once, one cycle wide, after strobe 1023.
  - chip_idx is 0 and the next 10 chips repeat 1440 octal.
  - Second period matches the first bit-for-bit.
- Load with prn=0, then prn=33: valid=0 and chip_idx frozen under chip_en strobes. A following load with prn=5 gives valid=1.
- In RUN at chip_idx=1022, assert load(prn=7) together with chip_en: no epoch; chip_idx=0; G1/G2 all ones; valid=1; PRN7 taps used.
- Assert rst=0 asynchronously mid-period, between clock edges: outputs clear immediately to reset values. chip_en after release leaves chip_idx at 0 until load.
